// File: rtl/fpu_divide.sv
// fpu_divide: restoring radix-2 mantissa divider producing one quotient bit per clock.
// Optional macro FPU_DIV_EARLY_EXIT_EN: finish as soon as the partial remainder reaches zero.
module fpu_divide #(
  parameter int WIDTH = 32,
  parameter int E     = 8,
  parameter int F     = 23,
  parameter int BIAS  = (1 << (E-1)) - 1,
  parameter int N     = F + 3 + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_sign,
  input  logic [E-1:0] a_exponent,
  input  logic [F:0]   a_fraction,
  input  logic         b_sign,
  input  logic [E-1:0] b_exponent,
  input  logic [F:0]   b_fraction,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         result_s,
  output logic [E-1:0] result_e,
  output logic [N-1:0] result_f
);
  localparam int CW = $clog2(N+1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  if (WIDTH < E + F + 1) begin : g_width_chk
    $error("fpu_divide: WIDTH too small for E+F+1");
  end

  logic [1:0]    state;
  logic [F+1:0]  rem, dvsr, r_sub, r_next;
  logic [N-1:0]  quo, q_next, fin_f;
  logic [CW-1:0] count;
  logic          q_bit, last;
  logic          sign_r;
  logic [E-1:0]  exp_r;

  // One restoring step; fin_f is the quotient as it would be reported if this step is the last.
  always_comb begin
    q_bit  = (rem >= dvsr);
    r_sub  = q_bit ? rem - dvsr : rem;
    r_next = r_sub << 1;
    q_next = {quo[N-2:0], q_bit};
    fin_f  = {q_next[N-1:1], q_next[0] | (r_next != '0)};
    last   = (count == CW'(N-1));
`ifdef FPU_DIV_EARLY_EXIT_EN
    if (r_next == '0) begin
      last  = 1'b1;
      fin_f = q_next << (CW'(N-1) - count);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
      result_s <= 1'b0;
      result_e <= '0;
      result_f <= '0;
      rem      <= '0;
      dvsr     <= '0;
      quo      <= '0;
      count    <= '0;
      sign_r   <= 1'b0;
      exp_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            dz     <= 1'b0;
            sign_r <= a_sign ^ b_sign;
            exp_r  <= a_exponent - b_exponent + E'(BIAS);
            rem    <= {1'b0, a_fraction};
            dvsr   <= {1'b0, b_fraction};
            quo    <= '0;
            count  <= '0;
            if (b_fraction == '0) begin
              state    <= S_FIN;
              done     <= 1'b1;
              dz       <= 1'b1;
              result_s <= a_sign ^ b_sign;
              result_e <= '1;
              result_f <= '1;
            end else begin
              state <= S_DIV;
              busy  <= 1'b1;
            end
          end
        end
        S_DIV: begin
          rem   <= r_next;
          quo   <= q_next;
          count <= count + CW'(1);
          if (last) begin
            state    <= S_FIN;
            busy     <= 1'b0;
            done     <= 1'b1;
            result_f <= fin_f;
            result_s <= sign_r;
            result_e <= exp_r;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
